alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational 32-bit MIPS ALU (instruction word, reg_a, reg_b in; 32-bit result and 3-bit flag out) among NUM_REQ requesters. Each requester presents an instruction word and two operands using a valid/ready handshake. The scheduler grants one requester at a time, registers the operands into the ALU, captures the result and flag, and returns them on a shared response channel tagged with the requester ID. It sits between the issue stages (or test masters) and the single shared ALU instance.

---
 rtl/alu_rr_scheduler.sv | 103 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter that time-shares one combinational ALU among NUM_REQ requesters.
// Each granted operation returns on a shared response channel, tagged with the requester ID.
module alu_rr_scheduler #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_inst,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           alu_inst,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_res,
  input  logic [2:0]            alu_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic [2:0]            rsp_flag,
  output logic                  busy,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            found;
  logic [ID_W-1:0] winner;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from rr_ptr upward with wrap; the first asserted valid wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[wrap_idx(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      alu_inst   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flag   <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            alu_inst <= req_inst[32*winner +: 32];
            alu_a    <= req_a[32*winner +: 32];
            alu_b    <= req_b[32*winner +: 32];
            grant_id <= winner;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_res;
          rsp_flag   <= alu_flag;
          rsp_id     <= grant_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // The pointer advances only once the response is consumed, so the next scan starts after the owner.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= wrap_idx(grant_id, 1);
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: a behavioural ALU stub, a transaction-level model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_alu_rr_scheduler;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_inst, req_a, req_b;
  logic [31:0]     alu_inst, alu_a, alu_b, alu_res;
  logic [2:0]      alu_flag;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic [2:0]      rsp_flag;
  logic            busy;
  logic [15:0]     op_count;

  int errors = 0;
  int checks = 0;

  alu_rr_scheduler #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inst(req_inst), .req_a(req_a), .req_b(req_b),
    .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU stub: flag = {zero, negative, signed overflow}.
  function automatic logic [34:0] alu_fn(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    r  = '0;
    ov = 1'b0;
    case (inst[5:0])
      6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h2A: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return {(r == 32'd0), r[31], ov, r};
  endfunction

  assign {alu_flag, alu_res} = alu_fn(alu_inst, alu_a, alu_b);

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N] === 1'b1) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one operation in flight, age counts edges since it was accepted.
  bit          m_init = 1'b0;
  bit          m_active;
  int          m_age, m_ptr, m_gid, m_rid;
  logic [31:0] m_inst, m_a, m_b, m_res;
  logic [2:0]  m_flag;
  logic [15:0] m_count;
  int          cyc = 0;
  int          glog[$];
  int          rlog_id[$];
  int          rlog_t[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) glog.push_back(i);
    if (rsp_valid === 1'b1 && rsp_ready && !rst) begin
      rlog_id.push_back(int'(rsp_id));
      rlog_t.push_back(cyc);
    end
    if (rst) begin
      m_init <= 1'b1; m_active <= 1'b0; m_age <= 0; m_ptr <= 0; m_gid <= 0; m_rid <= 0;
      m_inst <= '0; m_a <= '0; m_b <= '0; m_res <= '0; m_flag <= '0; m_count <= '0;
    end else if (m_init) begin
      if (!m_active) begin
        if (pick(m_ptr, req_valid) >= 0) begin
          m_active <= 1'b1;
          m_age    <= 0;
          m_gid    <= pick(m_ptr, req_valid);
          m_inst   <= req_inst[pick(m_ptr, req_valid)*32 +: 32];
          m_a      <= req_a[pick(m_ptr, req_valid)*32 +: 32];
          m_b      <= req_b[pick(m_ptr, req_valid)*32 +: 32];
        end
      end else if (m_age == 0) begin
        {m_flag, m_res} <= alu_fn(m_inst, m_a, m_b);
        m_rid <= m_gid;
        m_age <= 1;
      end else if (rsp_ready) begin
        m_active <= 1'b0;
        m_ptr    <= (m_gid + 1) % N;
        m_count  <= m_count + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      if (!m_active && pick(m_ptr, req_valid) >= 0) exp_ready[pick(m_ptr, req_valid)] = 1'b1;
      checkOutput("m_req_ready", req_ready, exp_ready);
      checkOutput("m_busy", busy, m_active);
      checkOutput("m_rsp_valid", rsp_valid, (m_active && m_age >= 1));
      checkOutput("m_rsp_id", rsp_id, m_rid);
      checkOutput("m_rsp_result", rsp_result, m_res);
      checkOutput("m_rsp_flag", rsp_flag, m_flag);
      checkOutput("m_alu_inst", alu_inst, m_inst);
      checkOutput("m_alu_a", alu_a, m_a);
      checkOutput("m_alu_b", alu_b, m_b);
      checkOutput("m_op_count", op_count, m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    #1;
  endtask

  task automatic setReq(input int id, input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    req_inst[id*32 +: 32] = inst;
    req_a[id*32 +: 32]    = a;
    req_b[id*32 +: 32]    = b;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) return;
      tick();
    end
    checkOutput("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expg[5];
    expg = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_inst = '0; req_a = '0; req_b = '0;
    tick(); tick();
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_alu_inst", alu_inst, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 0);

    // Add through requester 0 with signed overflow: result 0, flag {zero,neg,ov} = 101.
    setReq(0, 32'h20, 32'h8000_0000, 32'h8000_0000);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t1_ready", req_ready, 4'b0001);
    tick(); applyStimulus(4'b0000, 1'b1);
    checkOutput("t1_alu_inst", alu_inst, 32'h20);
    checkOutput("t1_exec_valid", rsp_valid, 0);
    tick();
    checkOutput("t1_rsp_valid", rsp_valid, 1);
    checkOutput("t1_rsp_id", rsp_id, 0);
    checkOutput("t1_rsp_result", rsp_result, 32'h0);
    checkOutput("t1_rsp_flag", rsp_flag, 3'b101);
    tick();
    checkOutput("t1_op_count", op_count, 1);
    checkOutput("t1_busy", busy, 0);

    // Round robin from a fresh pointer with every requester asking.
    rst = 1'b1; tick(); rst = 1'b0;
    glog.delete(); rlog_id.delete(); rlog_t.delete();
    for (int i = 0; i < N; i++) setReq(i, 32'h25, 32'(i), 32'h100);
    applyStimulus(4'b1111, 1'b1);
    repeat (15) tick();
    applyStimulus(4'b0000, 1'b1);
    waitIdle();
    checkOutput("rr_grant_count", (glog.size() >= 5), 1);
    checkOutput("rr_rsp_count", (rlog_id.size() >= 4), 1);
    if (glog.size() >= 5) for (int i = 0; i < 5; i++) checkOutput($sformatf("rr_grant%0d", i), glog[i], expg[i]);
    if (rlog_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_rsp_id%0d", i), rlog_id[i], expg[i]);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("rr_spacing%0d", i), rlog_t[i+1] - rlog_t[i], 3);
    end

    // Backpressure: response must hold while other requesters wait.
    setReq(2, 32'h25, 32'hF0, 32'hF00);
    applyStimulus(4'b0100, 1'b0);
    tick(); applyStimulus(4'b1011, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), rsp_valid, 1);
      checkOutput($sformatf("bp_id%0d", i), rsp_id, 2);
      checkOutput($sformatf("bp_result%0d", i), rsp_result, 32'hFF0);
      checkOutput($sformatf("bp_ready%0d", i), req_ready, 0);
      checkOutput($sformatf("bp_busy%0d", i), busy, 1);
      tick();
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("bp_done_valid", rsp_valid, 0);
    checkOutput("bp_done_busy", busy, 0);

    // Pointer wrap: grant 3, then 1001 held gives 0 then 3.
    glog.delete();
    setReq(3, 32'h20, 32'd1, 32'd2);
    setReq(0, 32'h22, 32'd5, 32'd7);
    applyStimulus(4'b1000, 1'b1);
    tick(); applyStimulus(4'b1001, 1'b1);
    repeat (6) tick();
    applyStimulus(4'b0000, 1'b1);
    waitIdle();
    checkOutput("wrap_count", (glog.size() >= 3), 1);
    if (glog.size() >= 3) begin
      checkOutput("wrap_g0", glog[0], 3);
      checkOutput("wrap_g1", glog[1], 0);
      checkOutput("wrap_g2", glog[2], 3);
    end

    // Operand capture: later operand changes must not leak into the result.
    setReq(2, 32'h24, 32'h9, 32'hD);
    applyStimulus(4'b0100, 1'b1);
    tick();
    req_a[2*32 +: 32] = 32'hFFFF_FFFF;
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("cap_result", rsp_result, 32'h9);
    checkOutput("cap_id", rsp_id, 2);
    tick();

    // Reset while executing drops the operation and rewinds the pointer.
    setReq(1, 32'h25, 32'h3, 32'h4);
    applyStimulus(4'b0010, 1'b1);
    tick();
    rst = 1'b1; applyStimulus(4'b0000, 1'b1);
    tick();
    rst = 1'b0; applyStimulus(4'b0000, 1'b1);
    checkOutput("rx_rsp_valid", rsp_valid, 0);
    checkOutput("rx_alu_inst", alu_inst, 0);
    checkOutput("rx_alu_a", alu_a, 0);
    checkOutput("rx_rsp_result", rsp_result, 0);
    checkOutput("rx_op_count", op_count, 0);
    checkOutput("rx_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rx_quiet%0d", i), rsp_valid, 0);
    end
    setReq(3, 32'h20, 32'h1, 32'h1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("rx_next_grant", req_ready, 4'b0010);
    tick(); applyStimulus(4'b0000, 1'b1);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
